// File: rtl/cpu_pkg.sv
// Shared constants and types for the five-stage MIPS core: instruction field
// positions, opcode/funct values, ALU operation codes and the pipeline control bundle.
package cpu_pkg;

  // Instruction geometry
  localparam int unsigned INSTR_W    = 32;
  localparam int unsigned IMM_W      = 16;
  localparam int unsigned FIELD_W    = 5;
  localparam int unsigned OPCODE_W   = 6;
  localparam int unsigned FUNCT_W    = 6;

  // Field bit positions (LSB of each field)
  localparam int unsigned OPCODE_LSB = 26;
  localparam int unsigned RS_LSB     = 21;
  localparam int unsigned RT_LSB     = 16;
  localparam int unsigned RD_LSB     = 11;
  localparam int unsigned SHAMT_LSB  = 6;
  localparam int unsigned FUNCT_LSB  = 0;
  localparam int unsigned IMM_LSB    = 0;
  localparam int unsigned IMM_SIGN   = IMM_LSB + IMM_W - 1;

  // Hard-wired zero register
  localparam logic [FIELD_W-1:0] REG_ZERO = 5'd0;

  // Primary opcodes
  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'h02;
  localparam logic [OPCODE_W-1:0] OP_JAL   = 6'h03;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OPCODE_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OPCODE_W-1:0] OP_ADDIU = 6'h09;
  localparam logic [OPCODE_W-1:0] OP_SLTI  = 6'h0A;
  localparam logic [OPCODE_W-1:0] OP_ANDI  = 6'h0C;
  localparam logic [OPCODE_W-1:0] OP_ORI   = 6'h0D;
  localparam logic [OPCODE_W-1:0] OP_LUI   = 6'h0F;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'h23;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'h2B;

  // R-type function codes
  localparam logic [FUNCT_W-1:0] FUNCT_SLL = 6'h00;
  localparam logic [FUNCT_W-1:0] FUNCT_SRL = 6'h02;
  localparam logic [FUNCT_W-1:0] FUNCT_JR  = 6'h08;
  localparam logic [FUNCT_W-1:0] FUNCT_ADD = 6'h20;
  localparam logic [FUNCT_W-1:0] FUNCT_SUB = 6'h22;
  localparam logic [FUNCT_W-1:0] FUNCT_AND = 6'h24;
  localparam logic [FUNCT_W-1:0] FUNCT_OR  = 6'h25;
  localparam logic [FUNCT_W-1:0] FUNCT_SLT = 6'h2A;

  // ALU operation codes
  localparam int unsigned ALUOP_BITS = 4;
  localparam logic [ALUOP_BITS-1:0] ALUOP_ADD = 4'h0;
  localparam logic [ALUOP_BITS-1:0] ALUOP_SUB = 4'h1;
  localparam logic [ALUOP_BITS-1:0] ALUOP_AND = 4'h2;
  localparam logic [ALUOP_BITS-1:0] ALUOP_OR  = 4'h3;
  localparam logic [ALUOP_BITS-1:0] ALUOP_SLT = 4'h4;
  localparam logic [ALUOP_BITS-1:0] ALUOP_SLL = 4'h5;
  localparam logic [ALUOP_BITS-1:0] ALUOP_SRL = 4'h6;
  localparam logic [ALUOP_BITS-1:0] ALUOP_LUI = 4'h7;

  // Single-bit control bundle carried down the pipeline
  typedef struct packed {
    logic regWrite;
    logic memRead;
    logic memWrite;
    logic memToReg;
    logic aluSrc;
    logic regDst;
  } ctrl_t;

endpackage : cpu_pkg

// File: rtl/load_use_hazard_unit.sv
// Load-use hazard detector (combinational).
// A load in EX whose destination (rt) is read by the instruction in ID forces a
// one-cycle stall; an EX-resolved flush overrides the stall so IF/ID can load the
// redirect target.
// Ports:
//   memReadEX  - EX instruction is a load
//   rtEX       - EX load destination register
//   rsID, rtID - source register fields of the ID instruction
//   flushID    - control-flow flush of the ID instruction
//   hazard     - load-use dependency detected (drives the bubble)
//   stallOut   - hold PC and IF/ID this cycle
module load_use_hazard_unit
  import cpu_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  memReadEX,
  input  logic [REG_ADDR_W-1:0] rtEX,
  input  logic [REG_ADDR_W-1:0] rsID,
  input  logic [REG_ADDR_W-1:0] rtID,
  input  logic                  flushID,
  output logic                  hazard,
  output logic                  stallOut
);

  logic rtIsZero;
  logic rsMatch;
  logic rtMatch;

  // Both source fields are compared regardless of format; a false stall is harmless.
  assign rtIsZero = (rtEX == REG_ADDR_W'(REG_ZERO));
  assign rsMatch  = (rtEX == rsID);
  assign rtMatch  = (rtEX == rtID);

  assign hazard   = memReadEX & ~rtIsZero & (rsMatch | rtMatch);
  assign stallOut = hazard & ~flushID;

endmodule : load_use_hazard_unit

// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage of the five-stage MIPS core.
// Captures operands, decoded fields, the extended immediate and control bits into
// the ID/EX register, and inserts a bubble on a load-use hazard or a flush.
// Ports:
//   CLK, RST_N                  - clock, async active-low reset
//   instrID, pcPlus4ID          - instruction and PC+4 held in IF/ID
//   readData1, readData2        - register-file operands (rs, rt)
//   regWriteID..regDstID        - single-bit decoded controls
//   extOpID                     - 1 = sign-extend imm16, 0 = zero-extend
//   aluOpID                     - ALU operation code
//   flushID                     - kill the ID instruction (taken branch/jump)
//   stallOut                    - combinational: hold PC and IF/ID
//   validEX                     - EX holds a real instruction
//   pcPlus4EX..aluOpEX          - registered ID/EX payload
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned ALUOP_W    = 4
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [INSTR_W-1:0]    instrID,
  input  logic [DATA_W-1:0]     pcPlus4ID,
  input  logic [DATA_W-1:0]     readData1,
  input  logic [DATA_W-1:0]     readData2,
  input  logic                  regWriteID,
  input  logic                  memReadID,
  input  logic                  memWriteID,
  input  logic                  memToRegID,
  input  logic                  aluSrcID,
  input  logic                  regDstID,
  input  logic                  extOpID,
  input  logic [ALUOP_W-1:0]    aluOpID,
  input  logic                  flushID,
  output logic                  stallOut,
  output logic                  validEX,
  output logic [DATA_W-1:0]     pcPlus4EX,
  output logic [DATA_W-1:0]     rsDataEX,
  output logic [DATA_W-1:0]     rtDataEX,
  output logic [DATA_W-1:0]     immEX,
  output logic [REG_ADDR_W-1:0] rsEX,
  output logic [REG_ADDR_W-1:0] rtEX,
  output logic [REG_ADDR_W-1:0] rdEX,
  output logic [4:0]            shamtEX,
  output logic                  regWriteEX,
  output logic                  memReadEX,
  output logic                  memWriteEX,
  output logic                  memToRegEX,
  output logic                  aluSrcEX,
  output logic                  regDstEX,
  output logic [ALUOP_W-1:0]    aluOpEX
);

  localparam int unsigned SHAMT_W = 5;

  // Decoded fields of the ID instruction
  logic [REG_ADDR_W-1:0] rsID;
  logic [REG_ADDR_W-1:0] rtID;
  logic [REG_ADDR_W-1:0] rdID;
  logic [SHAMT_W-1:0]    shamtID;
  logic [IMM_W-1:0]      imm16ID;
  logic [DATA_W-1:0]     immExtID;
  logic [OPCODE_W-1:0]   unusedOpcode;

  assign rsID         = REG_ADDR_W'(instrID[RS_LSB +: FIELD_W]);
  assign rtID         = REG_ADDR_W'(instrID[RT_LSB +: FIELD_W]);
  assign rdID         = REG_ADDR_W'(instrID[RD_LSB +: FIELD_W]);
  assign shamtID      = instrID[SHAMT_LSB +: SHAMT_W];
  assign imm16ID      = instrID[IMM_LSB +: IMM_W];
  // Opcode is fully decoded upstream; this stage never looks at it.
  assign unusedOpcode = instrID[OPCODE_LSB +: OPCODE_W];

  // Immediate extender
  always_comb begin
    immExtID = {{(DATA_W-IMM_W){1'b0}}, imm16ID};
    if (extOpID) begin
      immExtID = {{(DATA_W-IMM_W){instrID[IMM_SIGN]}}, imm16ID};
    end
  end

  // Registered control bundle
  ctrl_t ctrlID;
  ctrl_t ctrlEX;
  ctrl_t ctrlNext;

  assign ctrlID = '{
    regWrite: regWriteID,
    memRead:  memReadID,
    memWrite: memWriteID,
    memToReg: memToRegID,
    aluSrc:   aluSrcID,
    regDst:   regDstID
  };

  // Load-use hazard detection
  logic hazard;

  load_use_hazard_unit #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_hazard (
    .memReadEX (ctrlEX.memRead),
    .rtEX      (rtEX),
    .rsID      (rsID),
    .rtID      (rtID),
    .flushID   (flushID),
    .hazard    (hazard),
    .stallOut  (stallOut)
  );

  // Bubble mux: a killed or stalled instruction becomes an all-zero, invalid slot
  logic                  bubble;
  logic                  validNext;
  logic [DATA_W-1:0]     pcPlus4Next;
  logic [DATA_W-1:0]     rsDataNext;
  logic [DATA_W-1:0]     rtDataNext;
  logic [DATA_W-1:0]     immNext;
  logic [REG_ADDR_W-1:0] rsNext;
  logic [REG_ADDR_W-1:0] rtNext;
  logic [REG_ADDR_W-1:0] rdNext;
  logic [SHAMT_W-1:0]    shamtNext;
  logic [ALUOP_W-1:0]    aluOpNext;

  assign bubble = flushID | hazard;

  always_comb begin
    validNext   = 1'b0;
    pcPlus4Next = '0;
    rsDataNext  = '0;
    rtDataNext  = '0;
    immNext     = '0;
    rsNext      = '0;
    rtNext      = '0;
    rdNext      = '0;
    shamtNext   = '0;
    ctrlNext    = '0;
    aluOpNext   = '0;
    if (!bubble) begin
      validNext   = 1'b1;
      pcPlus4Next = pcPlus4ID;
      rsDataNext  = readData1;
      rtDataNext  = readData2;
      immNext     = immExtID;
      rsNext      = rsID;
      rtNext      = rtID;
      rdNext      = rdID;
      shamtNext   = shamtID;
      ctrlNext    = ctrlID;
      aluOpNext   = aluOpID;
    end
  end

  // ID/EX register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      validEX   <= 1'b0;
      pcPlus4EX <= '0;
      rsDataEX  <= '0;
      rtDataEX  <= '0;
      immEX     <= '0;
      rsEX      <= '0;
      rtEX      <= '0;
      rdEX      <= '0;
      shamtEX   <= '0;
      ctrlEX    <= '0;
      aluOpEX   <= '0;
    end else begin
      validEX   <= validNext;
      pcPlus4EX <= pcPlus4Next;
      rsDataEX  <= rsDataNext;
      rtDataEX  <= rtDataNext;
      immEX     <= immNext;
      rsEX      <= rsNext;
      rtEX      <= rtNext;
      rdEX      <= rdNext;
      shamtEX   <= shamtNext;
      ctrlEX    <= ctrlNext;
      aluOpEX   <= aluOpNext;
    end
  end

  // Unpack the registered control bundle
  assign regWriteEX = ctrlEX.regWrite;
  assign memReadEX  = ctrlEX.memRead;
  assign memWriteEX = ctrlEX.memWrite;
  assign memToRegEX = ctrlEX.memToReg;
  assign aluSrcEX   = ctrlEX.aluSrc;
  assign regDstEX   = ctrlEX.regDst;

endmodule : id_ex_stage

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed vector table, hand-written reset
// sequences and a randomized run against a behavioural model of the ID/EX register.
module tb_id_ex_stage;

  logic        CLK;
  logic        RST_N;
  logic [31:0] instrID;
  logic [31:0] pcPlus4ID;
  logic [31:0] readData1;
  logic [31:0] readData2;
  logic        regWriteID, memReadID, memWriteID, memToRegID, aluSrcID, regDstID;
  logic        extOpID;
  logic [3:0]  aluOpID;
  logic        flushID;
  logic        stallOut;
  logic        validEX;
  logic [31:0] pcPlus4EX, rsDataEX, rtDataEX, immEX;
  logic [4:0]  rsEX, rtEX, rdEX, shamtEX;
  logic        regWriteEX, memReadEX, memWriteEX, memToRegEX, aluSrcEX, regDstEX;
  logic [3:0]  aluOpEX;

  id_ex_stage #(
    .DATA_W     (32),
    .REG_ADDR_W (5),
    .ALUOP_W    (4)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .instrID    (instrID),
    .pcPlus4ID  (pcPlus4ID),
    .readData1  (readData1),
    .readData2  (readData2),
    .regWriteID (regWriteID),
    .memReadID  (memReadID),
    .memWriteID (memWriteID),
    .memToRegID (memToRegID),
    .aluSrcID   (aluSrcID),
    .regDstID   (regDstID),
    .extOpID    (extOpID),
    .aluOpID    (aluOpID),
    .flushID    (flushID),
    .stallOut   (stallOut),
    .validEX    (validEX),
    .pcPlus4EX  (pcPlus4EX),
    .rsDataEX   (rsDataEX),
    .rtDataEX   (rtDataEX),
    .immEX      (immEX),
    .rsEX       (rsEX),
    .rtEX       (rtEX),
    .rdEX       (rdEX),
    .shamtEX    (shamtEX),
    .regWriteEX (regWriteEX),
    .memReadEX  (memReadEX),
    .memWriteEX (memWriteEX),
    .memToRegEX (memToRegEX),
    .aluSrcEX   (aluSrcEX),
    .regDstEX   (regDstEX),
    .aluOpEX    (aluOpEX)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  int nVec = 0;
  int nMis = 0;

  // Expected contents of the EX slot
  typedef struct {
    logic        valid;
    logic [31:0] pc, rsD, rtD, imm;
    logic [4:0]  rs, rt, rd, sh;
    logic        rw, mr, mw, m2r, as, rdst;
    logic [3:0]  op;
  } exp_t;

  exp_t m;

  typedef struct {
    logic [31:0] instr;
    logic        ext;
    logic        memRd;
    logic        flush;
    logic [31:0] rd1;
    logic        expStall;
    logic        expValid;
    logic [31:0] expImm;
    logic [31:0] expRsData;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    nVec++;
    if (act !== req) begin
      nMis++;
      $display("FAIL %s: got %h, required %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t emptySlot();
    exp_t e;
    e = '{valid: 1'b0, pc: '0, rsD: '0, rtD: '0, imm: '0, rs: '0, rt: '0, rd: '0, sh: '0,
          rw: 1'b0, mr: 1'b0, mw: 1'b0, m2r: 1'b0, as: 1'b0, rdst: 1'b0, op: '0};
    return e;
  endfunction

  // A load in EX writing a nonzero register that the ID instruction names as a source
  function automatic logic loadUse();
    logic [4:0] srcA, srcB;
    srcA = instrID[25:21];
    srcB = instrID[20:16];
    return m.mr && (m.rt != 5'd0) && (m.rt == srcA || m.rt == srcB);
  endfunction

  function automatic logic modelStall();
    return loadUse() && !flushID;
  endfunction

  // Advance the model by one clock edge using the currently driven ID inputs
  task automatic modelEdge();
    exp_t n;
    if (flushID || loadUse()) begin
      n = emptySlot();
    end else begin
      n.valid = 1'b1;
      n.pc    = pcPlus4ID;
      n.rsD   = readData1;
      n.rtD   = readData2;
      n.imm   = extOpID ? {{16{instrID[15]}}, instrID[15:0]} : {16'h0000, instrID[15:0]};
      n.rs    = instrID[25:21];
      n.rt    = instrID[20:16];
      n.rd    = instrID[15:11];
      n.sh    = instrID[10:6];
      n.rw    = regWriteID;
      n.mr    = memReadID;
      n.mw    = memWriteID;
      n.m2r   = memToRegID;
      n.as    = aluSrcID;
      n.rdst  = regDstID;
      n.op    = aluOpID;
    end
    m = n;
  endtask

  task automatic compareAll();
    chk("validEX",    32'(validEX),    32'(m.valid));
    chk("pcPlus4EX",  pcPlus4EX,       m.pc);
    chk("rsDataEX",   rsDataEX,        m.rsD);
    chk("rtDataEX",   rtDataEX,        m.rtD);
    chk("immEX",      immEX,           m.imm);
    chk("rsEX",       32'(rsEX),       32'(m.rs));
    chk("rtEX",       32'(rtEX),       32'(m.rt));
    chk("rdEX",       32'(rdEX),       32'(m.rd));
    chk("shamtEX",    32'(shamtEX),    32'(m.sh));
    chk("regWriteEX", 32'(regWriteEX), 32'(m.rw));
    chk("memReadEX",  32'(memReadEX),  32'(m.mr));
    chk("memWriteEX", 32'(memWriteEX), 32'(m.mw));
    chk("memToRegEX", 32'(memToRegEX), 32'(m.m2r));
    chk("aluSrcEX",   32'(aluSrcEX),   32'(m.as));
    chk("regDstEX",   32'(regDstEX),   32'(m.rdst));
    chk("aluOpEX",    32'(aluOpEX),    32'(m.op));
  endtask

  task automatic randomSide();
    pcPlus4ID  = $urandom;
    readData1  = $urandom;
    readData2  = $urandom;
    regWriteID = 1'($urandom);
    memWriteID = 1'($urandom);
    memToRegID = 1'($urandom);
    aluSrcID   = 1'($urandom);
    regDstID   = 1'($urandom);
    aluOpID    = 4'($urandom);
  endtask

  // One clock: check stallOut mid-cycle, clock, then check the EX slot
  task automatic step();
    @(negedge CLK);
    chk("stallOut", 32'(stallOut), 32'(modelStall()));
    @(posedge CLK);
    modelEdge();
    #1;
    compareAll();
  endtask

  function automatic logic [31:0] mkR(input int rs, input int rt, input int rd);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'h20};
  endfunction

  function automatic logic [31:0] mkLw(input int rs, input int rt);
    return {6'h23, 5'(rs), 5'(rt), 16'h0000};
  endfunction

  initial begin
    // Directed table: {instr, ext, memRead, flush, rd1, stall, valid, imm, rsData}
    tbl.push_back('{32'h2128_0005, 1'b1, 1'b0, 1'b0, 32'd7,  1'b0, 1'b1, 32'h0000_0005, 32'd7});
    tbl.push_back('{32'h2128_FFFC, 1'b1, 1'b0, 1'b0, 32'd11, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'd11});
    tbl.push_back('{32'h2128_FFFC, 1'b0, 1'b0, 1'b0, 32'd12, 1'b0, 1'b1, 32'h0000_FFFC, 32'd12});
    tbl.push_back('{mkLw(1, 2),    1'b1, 1'b1, 1'b0, 32'd13, 1'b0, 1'b1, 32'h0000_0000, 32'd13});
    tbl.push_back('{mkR(2, 4, 3),  1'b1, 1'b0, 1'b0, 32'd14, 1'b1, 1'b0, 32'h0000_0000, 32'd0});
    tbl.push_back('{mkR(2, 4, 3),  1'b1, 1'b0, 1'b0, 32'd15, 1'b0, 1'b1, 32'h0000_1820, 32'd15});
    tbl.push_back('{mkLw(1, 0),    1'b1, 1'b1, 1'b0, 32'd16, 1'b0, 1'b1, 32'h0000_0000, 32'd16});
    tbl.push_back('{mkR(0, 4, 3),  1'b1, 1'b0, 1'b0, 32'd17, 1'b0, 1'b1, 32'h0000_1820, 32'd17});
    tbl.push_back('{mkLw(1, 2),    1'b1, 1'b1, 1'b0, 32'd18, 1'b0, 1'b1, 32'h0000_0000, 32'd18});
    tbl.push_back('{mkR(2, 4, 3),  1'b1, 1'b0, 1'b1, 32'd19, 1'b0, 1'b0, 32'h0000_0000, 32'd0});
    tbl.push_back('{mkLw(1, 2),    1'b1, 1'b1, 1'b0, 32'd20, 1'b0, 1'b1, 32'h0000_0000, 32'd20});
    tbl.push_back('{mkLw(2, 5),    1'b1, 1'b1, 1'b0, 32'd21, 1'b1, 1'b0, 32'h0000_0000, 32'd0});
    tbl.push_back('{mkLw(2, 5),    1'b1, 1'b1, 1'b0, 32'd22, 1'b0, 1'b1, 32'h0000_0000, 32'd22});
    tbl.push_back('{mkR(5, 4, 3),  1'b1, 1'b0, 1'b0, 32'd23, 1'b1, 1'b0, 32'h0000_0000, 32'd0});
    tbl.push_back('{mkR(5, 4, 3),  1'b1, 1'b0, 1'b0, 32'd24, 1'b0, 1'b1, 32'h0000_1820, 32'd24});
    tbl.push_back('{mkLw(1, 7),    1'b1, 1'b1, 1'b0, 32'd25, 1'b0, 1'b1, 32'h0000_0000, 32'd25});
    tbl.push_back('{mkR(4, 7, 3),  1'b1, 1'b0, 1'b0, 32'd26, 1'b1, 1'b0, 32'h0000_0000, 32'd0});
    tbl.push_back('{mkR(4, 7, 3),  1'b1, 1'b0, 1'b0, 32'd27, 1'b0, 1'b1, 32'h0000_1820, 32'd27});

    // Reset with random inputs
    RST_N = 1'b1;
    instrID = $urandom;
    extOpID = 1'($urandom);
    memReadID = 1'($urandom);
    flushID = 1'b0;
    randomSide();
    #1 RST_N = 1'b0;
    m = emptySlot();
    #11;
    compareAll();
    chk("stallOut_reset", 32'(stallOut), 32'd0);
    #5 RST_N = 1'b1;

    // Directed vectors
    for (int i = 0; i < tbl.size(); i++) begin
      randomSide();
      instrID   = tbl[i].instr;
      extOpID   = tbl[i].ext;
      memReadID = tbl[i].memRd;
      flushID   = tbl[i].flush;
      readData1 = tbl[i].rd1;
      @(negedge CLK);
      chk($sformatf("tbl%0d_stall", i), 32'(stallOut), 32'(tbl[i].expStall));
      @(posedge CLK);
      modelEdge();
      #1;
      chk($sformatf("tbl%0d_valid", i), 32'(validEX), 32'(tbl[i].expValid));
      chk($sformatf("tbl%0d_imm", i), immEX, tbl[i].expImm);
      chk($sformatf("tbl%0d_rsData", i), rsDataEX, tbl[i].expRsData);
      compareAll();
    end
    chk("tbl_last_rsEX", 32'(rsEX), 32'd4);
    chk("tbl_last_rtEX", 32'(rtEX), 32'd7);

    // Async reset while stalled
    randomSide();
    instrID = mkLw(1, 2); memReadID = 1'b1; flushID = 1'b0; extOpID = 1'b1;
    step();
    randomSide();
    instrID = mkR(2, 4, 3); memReadID = 1'b0;
    @(negedge CLK);
    chk("stall_before_reset", 32'(stallOut), 32'd1);
    #2 RST_N = 1'b0;
    m = emptySlot();
    #1;
    chk("stall_during_reset", 32'(stallOut), 32'd0);
    compareAll();
    @(posedge CLK);
    #1;
    compareAll();
    RST_N = 1'b1;
    step();
    chk("restart_rsEX", 32'(rsEX), 32'd2);

    // Randomized run with a narrow register range to provoke hazards
    for (int c = 0; c < 2000; c++) begin
      randomSide();
      instrID   = {6'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
      extOpID   = 1'($urandom);
      memReadID = ($urandom_range(0, 9) < 4);
      flushID   = ($urandom_range(0, 9) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule : tb_id_ex_stage
